seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//   Monitors a multiplexed, active-low common-anode 7-segment display bus
//   (digit-select an + segment lines seg) and recovers the hex value being shown.
//   Each digit is decoded only after its select and segment levels have been
//   stable long enough; the decoded digits are assembled into a 32-bit word.
//   Sits beside the display driver for self-check and for readback in the lab benches.
// PARAMETERS
//   NDIG        8   number of multiplexed digits (an width); the value width is 4*NDIG
//   STABLE_CYC  16  consecutive identical samples required before a digit is captured (>=2)
// PORTS
//   clk          in   1       system clock
//   rst_n        in   1       asynchronous active-low reset
//   an           in   NDIG    digit select, active low, asynchronous to clk
//   seg          in   8       segment lines, active low; seg[7]=dp, seg[6:0]=g..a
//   value        out  4*NDIG  live decoded digits; digit i is in value[4*i+3:4*i]
//   dig_vld      out  NDIG    digit i has been captured at least once since reset
//   dp_on        out  NDIG    decimal point of digit i lit at its last capture (~seg[7])
//   cap_stb      out  1       1-cycle pulse: a digit was captured this cycle
//   err_stb      out  1       1-cycle pulse: a stable pattern was not in the code table
//   err_dig      out  3       index of the digit that raised the last error
//   frame_done   out  1       1-cycle pulse: all NDIG digits captured since the last frame
//   frame_value  out  4*NDIG  snapshot of value taken at frame_done
// BEHAVIOUR
//   - Reset: every output is 0; the synchroniser, counter, seen mask and FSM are cleared.
//     Reset mid-operation discards any partial frame.
//   - an and seg each pass through a 2-flop synchroniser, giving 2 cycles of latency.
//   - Code table on seg[6:0], 0..F in order: 40 79 24 30 19 12 02 78 00 18 08 03 46 21 06 0E.
//     seg[7] is excluded from the lookup.
//   - FSM states:
//     IDLE   : synced an is not one-hot-low (zero or >1 bits low); the counter is held at 0.
//     SETTLE : an is one-hot-low; cnt++ on each cycle where the sample equals the previous one.
//              Any change in an or seg sets cnt to 0 (stay in SETTLE, or go to IDLE if an is invalid).
//              When cnt reaches STABLE_CYC-1, capture and move to HOLD.
//     HOLD   : no further capture until the sample changes; then go to SETTLE (cnt=0) or IDLE.
//   - Capture (registered, visible on the next edge) for digit i:
//     valid pattern   -> value nibble i <= code, dig_vld[i]<=1, dp_on[i]<=~seg[7],
//                        seen[i]<=1, cap_stb=1.
//     invalid pattern -> nibble, dig_vld and seen are unchanged; err_stb=1, err_dig<=i;
//                        cap_stb stays 0.
//   - Frame: if (seen | capture bit) becomes all-ones, then in the same cycle as that cap_stb:
//     frame_done=1, frame_value <= value including the new nibble, and seen <= 0.
//     A repeat capture of an already-seen digit is allowed and overwrites the nibble.
//   - Digit index = position of the single low bit in an; bit 0 is the rightmost digit.
// CONFIGURATION
//   SEG_BLANK_DETECT_EN defined: seg[6:0]=7F (all segments off) is a legal "blank".
//     It sets seen[i], clears dig_vld[i], leaves the nibble unchanged, pulses cap_stb
//     and does not pulse err_stb.
//   Not defined: 7F is an invalid pattern and takes the err_stb path.
// STRUCTURE
//   seg_pkg: the 16 pattern localparams SEG_0..SEG_F, SEG_BLANK=7'h7F, and the FSM state
//     encoding (IDLE/SETTLE/HOLD).
//   Sub-module seg_pattern_lookup: combinational seg[6:0] -> {hit, code[3:0]} using seg_pkg.
//   Top level holds the synchronisers, stability counter, FSM, seen mask and output registers.
// TESTING
//   1 Assert rst_n=0 mid-scan -> all outputs 0 within one edge; no pulses after release.
//   2 an=FE, seg=C0 held 20 cycles -> one cap_stb about 18 cycles after the first sample;
//     value[3:0]=0, dig_vld=01; no second pulse while held.
//   3 an=F7, seg=92 for 10 cycles, then seg=82 for 20 cycles -> no capture for 92;
//     value[15:12]=6 after the 82 period.
//   4 Scan digits 0..7 with codes 1..8, 20 cycles each -> frame_done together with the
//     8th cap_stb; frame_value=87654321.
//   5 an=FB, seg=AA for 20 cycles -> err_stb once, err_dig=2, value[11:8] unchanged.
//   6 an=FC or an=FF, seg=C0 -> no capture. Digit 0 with seg=FF -> blank capture
//     with SEG_BLANK_DETECT_EN, err_stb without it.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan decoder.
// Segment patterns (seg[6:0], g..a, active low) and FSM state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h18;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational segment pattern -> hex nibble lookup.
// Ports: seg_i[6:0] in; hit_o (pattern in table), code_o[3:0] out.
module seg_pattern_lookup
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       hit_o,
  output logic [3:0] code_o
);

  always_comb begin
    hit_o  = 1'b1;
    code_o = 4'h0;
    unique case (seg_i)
      SEG_0:   code_o = 4'h0;
      SEG_1:   code_o = 4'h1;
      SEG_2:   code_o = 4'h2;
      SEG_3:   code_o = 4'h3;
      SEG_4:   code_o = 4'h4;
      SEG_5:   code_o = 4'h5;
      SEG_6:   code_o = 4'h6;
      SEG_7:   code_o = 4'h7;
      SEG_8:   code_o = 4'h8;
      SEG_9:   code_o = 4'h9;
      SEG_A:   code_o = 4'hA;
      SEG_B:   code_o = 4'hB;
      SEG_C:   code_o = 4'hC;
      SEG_D:   code_o = 4'hD;
      SEG_E:   code_o = 4'hE;
      SEG_F:   code_o = 4'hF;
      default: hit_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus.
// Ports: clk, rst_n, an[NDIG], seg[8] in; value, dig_vld, dp_on,
//   cap_stb, err_stb, err_dig, frame_done, frame_value out.
// Option: SEG_BLANK_DETECT_EN accepts seg[6:0]=7F as a blank digit.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NDIG       = 8,
  parameter int STABLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NDIG-1:0]   an,
  input  logic [7:0]        seg,
  output logic [4*NDIG-1:0] value,
  output logic [NDIG-1:0]   dig_vld,
  output logic [NDIG-1:0]   dp_on,
  output logic              cap_stb,
  output logic              err_stb,
  output logic [2:0]        err_dig,
  output logic              frame_done,
  output logic [4*NDIG-1:0] frame_value
);

  localparam int CW = $clog2(STABLE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

  logic [NDIG-1:0]   an_q1, an_q2, an_q3;
  logic [7:0]        seg_q1, seg_q2, seg_q3;
  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic [4*NDIG-1:0] value_q, value_d;
  logic [NDIG-1:0]   vld_q, dp_q;
  logic              cap_q, err_q, frm_q;
  logic [2:0]        edig_q;
  logic [4*NDIG-1:0] fval_q;

  logic [NDIG-1:0] dsel;
  logic            an_ok, same;
  logic [2:0]      idx;
  logic            hit, blank, cap_go;
  logic [3:0]      code;

  // q2 is the synchronised sample; q3 is the previous one
  assign dsel  = ~an_q2;
  assign an_ok = $onehot(dsel);
  assign same  = (an_q2 == an_q3) && (seg_q2 == seg_q3);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (dsel[i]) idx = 3'(i);
    end
  end

  seg_pattern_lookup u_lookup (
    .seg_i  (seg_q2[6:0]),
    .hit_o  (hit),
    .code_o (code)
  );

`ifdef SEG_BLANK_DETECT_EN
  assign blank = (seg_q2[6:0] == SEG_BLANK);
`else
  assign blank = 1'b0;
`endif

  assign cap_go = (state_q == ST_SETTLE) && an_ok
               && same && (cnt_q == CNT_MAX);

  always_comb begin
    value_d = value_q;
    if (hit) value_d[4*idx +: 4] = code;
    seen_d = seen_q | dsel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q1   <= '0;
      an_q2   <= '0;
      an_q3   <= '0;
      seg_q1  <= '0;
      seg_q2  <= '0;
      seg_q3  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      seen_q  <= '0;
      value_q <= '0;
      vld_q   <= '0;
      dp_q    <= '0;
      cap_q   <= 1'b0;
      err_q   <= 1'b0;
      frm_q   <= 1'b0;
      edig_q  <= '0;
      fval_q  <= '0;
    end else begin
      an_q1  <= an;
      an_q2  <= an_q1;
      an_q3  <= an_q2;
      seg_q1 <= seg;
      seg_q2 <= seg_q1;
      seg_q3 <= seg_q2;
      cap_q  <= 1'b0;
      err_q  <= 1'b0;
      frm_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (an_ok) state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (!an_ok) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (!same) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          cnt_q <= '0;
          if (!an_ok) state_q <= ST_IDLE;
          else if (!same) state_q <= ST_SETTLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase

      if (cap_go) begin
        if (hit || blank) begin
          value_q     <= value_d;
          vld_q[idx]  <= hit;
          dp_q[idx]   <= ~seg_q2[7];
          cap_q       <= 1'b1;
          if (&seen_d) begin
            frm_q  <= 1'b1;
            fval_q <= value_d;
            seen_q <= '0;
          end else begin
            seen_q <= seen_d;
          end
        end else begin
          err_q  <= 1'b1;
          edig_q <= idx;
        end
      end
    end
  end

  assign value       = value_q;
  assign dig_vld     = vld_q;
  assign dp_on       = dp_q;
  assign cap_stb     = cap_q;
  assign err_stb     = err_q;
  assign err_dig     = edig_q;
  assign frame_done  = frm_q;
  assign frame_value = fval_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder.
// Table of scan steps plus hand sequences for latency and reset.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  an, seg;
  logic [31:0] value, frame_value;
  logic [7:0]  dig_vld, dp_on;
  logic        cap_stb, err_stb, frame_done;
  logic [2:0]  err_dig;

  seg_scan_decoder #(.NDIG(8), .STABLE_CYC(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
    .value       (value),
    .dig_vld     (dig_vld),
    .dp_on       (dp_on),
    .cap_stb     (cap_stb),
    .err_stb     (err_stb),
    .err_dig     (err_dig),
    .frame_done  (frame_done),
    .frame_value (frame_value)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ncap  = 0;
  int nerr  = 0;
  int nfrm  = 0;
  int nlone = 0;

  always @(negedge clk) begin
    if (cap_stb) ncap++;
    if (err_stb) nerr++;
    if (frame_done) nfrm++;
    if (frame_done && !cap_stb) nlone++;
  end

  typedef struct {
    logic [7:0]  an;
    logic [7:0]  seg;
    int          cyc;
    int          dcap;
    int          derr;
    int          dfrm;
    logic [31:0] val;
    logic [7:0]  vld;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [7:0] a, input logic [7:0] s,
                       input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
    #1;
  endtask

`ifdef SEG_BLANK_DETECT_EN
  localparam int BL_CAP = 1;
  localparam int BL_ERR = 0;
  localparam logic [7:0] BL_VLD = 8'hFE;
`else
  localparam int BL_CAP = 0;
  localparam int BL_ERR = 1;
  localparam logic [7:0] BL_VLD = 8'hFF;
`endif

  initial begin
    int c0, e0, f0, lat;

    tv.push_back('{8'hFE, 8'hC0, 20, 1, 0, 0, 32'h0000_0000, 8'h01});
    tv.push_back('{8'hFE, 8'hC0, 20, 0, 0, 0, 32'h0000_0000, 8'h01});
    tv.push_back('{8'hF7, 8'h92, 10, 0, 0, 0, 32'h0000_0000, 8'h01});
    tv.push_back('{8'hF7, 8'h82, 20, 1, 0, 0, 32'h0000_6000, 8'h09});
    tv.push_back('{8'hFB, 8'hAA, 20, 0, 1, 0, 32'h0000_6000, 8'h09});
    tv.push_back('{8'hFC, 8'hC0, 20, 0, 0, 0, 32'h0000_6000, 8'h09});
    tv.push_back('{8'hFF, 8'hC0, 20, 0, 0, 0, 32'h0000_6000, 8'h09});
    tv.push_back('{8'hFE, 8'h79, 20, 1, 0, 0, 32'h0000_6001, 8'h09});
    tv.push_back('{8'hFD, 8'hA4, 20, 1, 0, 0, 32'h0000_6021, 8'h0B});
    tv.push_back('{8'hFB, 8'hB0, 20, 1, 0, 0, 32'h0000_6321, 8'h0F});
    tv.push_back('{8'hF7, 8'h99, 20, 1, 0, 0, 32'h0000_4321, 8'h0F});
    tv.push_back('{8'hEF, 8'h92, 20, 1, 0, 0, 32'h0005_4321, 8'h1F});
    tv.push_back('{8'hDF, 8'h82, 20, 1, 0, 0, 32'h0065_4321, 8'h3F});
    tv.push_back('{8'hBF, 8'hF8, 20, 1, 0, 0, 32'h0765_4321, 8'h7F});
    tv.push_back('{8'h7F, 8'h80, 20, 1, 0, 1, 32'h8765_4321, 8'hFF});
    tv.push_back('{8'hFE, 8'hFF, 20, BL_CAP, BL_ERR, 0,
                   32'h8765_4321, BL_VLD});

    rst_n = 1'b0;
    an    = 8'hFF;
    seg   = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_value", value, 32'h0);
    chk("rst_vld", {24'h0, dig_vld}, 32'h0);
    chk("rst_dp", {24'h0, dp_on}, 32'h0);
    chk("rst_pulses", {29'h0, cap_stb, err_stb, frame_done}, 32'h0);
    chk("rst_fval", frame_value, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      c0 = ncap;
      e0 = nerr;
      f0 = nfrm;
      apply(tv[i].an, tv[i].seg, tv[i].cyc);
      chk($sformatf("v%0d_cap", i), ncap - c0, tv[i].dcap);
      chk($sformatf("v%0d_err", i), nerr - e0, tv[i].derr);
      chk($sformatf("v%0d_frm", i), nfrm - f0, tv[i].dfrm);
      chk($sformatf("v%0d_val", i), value, tv[i].val);
      chk($sformatf("v%0d_vld", i), {24'h0, dig_vld}, {24'h0, tv[i].vld});
      if (i == 4) chk("err_dig", {29'h0, err_dig}, 32'h2);
      if (i == 14) begin
        chk("frame_value", frame_value, 32'h8765_4321);
        chk("frame_lone", nlone, 0);
        chk("dp_on", {24'h0, dp_on}, 32'h01);
      end
    end

    // capture latency from first drive of a new digit
    an  = 8'hFD;
    seg = 8'h98;
    lat = 0;
    while (!cap_stb && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat < 17 || lat > 20) begin
      bad++;
      $display("FAIL cap_latency: got %0d expected 17..20", lat);
    end
    chk("lat_value", value, 32'h8765_4391);
    apply(8'hFD, 8'h98, 5);

    // reset in the middle of settling a digit
    apply(8'hFB, 8'hA4, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_value", value, 32'h0);
    chk("mrst_vld", {24'h0, dig_vld}, 32'h0);
    chk("mrst_misc", {dp_on, 21'h0, err_dig}, 32'h0);
    chk("mrst_fval", frame_value, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    c0 = ncap;
    e0 = nerr;
    f0 = nfrm;
    apply(8'hFF, 8'hFF, 20);
    chk("post_rst_pulses", (ncap - c0) + (nerr - e0) + (nfrm - f0), 0);
    chk("post_rst_value", value, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
